axi_lite_mem_slave: RTL



---
 rtl/axi_mem_pkg.sv | 26 ++
 rtl/mem_ram_bytewe.sv | 43 ++++
 rtl/axi_lite_mem_slave.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_pkg.sv
// Shared definitions for the AXI4-Lite memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_mem_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_DATA = 2'b01
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE  = 2'b00,
    W_GOT_A = 2'b01,
    W_GOT_D = 2'b10,
    W_RESP  = 2'b11
  } w_state_t;

  // 4-bit increment that sticks at its maximum instead of wrapping
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/mem_ram_bytewe.sv
// Word RAM with one registered read port and one byte-enabled write port.
// Latency: read data valid the cycle after rd_en; writes land on the same edge.
// Backpressure: none; read output holds its value while rd_en is low.
module mem_ram_bytewe
  import axi_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              rd_clr,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes; lanes with a clear strobe keep their old contents
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_strb[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Registered read; sampling the array before the write above settles gives read-first
  always_ff @(posedge clock) begin
    if (rd_clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder over a byte-writable word RAM; read and write channels are independent.
// Latency: Rvalid one cycle after AR handshake, Bvalid one cycle after commit (plus waits with AXI_MEM_WAIT_EN).
// Backpressure: one transaction per channel; ready drops until the response is accepted.
module axi_lite_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int ADDR_W      = $clog2(MEM_WORDS),
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] AWdata,
  input  logic              AWvalid,
  output logic              AWready,
  input  logic [2:0]        awprot,
  input  logic [DATA_W-1:0] Wdata,
  input  logic [STRB_W-1:0] Wstrb,
  input  logic              Wvalid,
  output logic              Wready,
  output logic              Bvalid,
  input  logic              Bready,
  input  logic [DATA_W-1:0] ARdata,
  input  logic [2:0]        arprot,
  input  logic              ARvalid,
  output logic              ARready,
  output logic [DATA_W-1:0] Rdata,
  output logic              Rvalid,
  input  logic              RReady
);

  r_state_t r_state;
  w_state_t w_state;

  logic              ar_hs;
  logic              aw_hs;
  logic              w_hs;
  logic              commit;
  logic              rd_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;

  logic [ADDR_W-1:0] aw_idx_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  // Wait-state hooks; in the zero-wait build they are constant true
  logic ar_rdy_nxt;
  logic aw_rdy_nxt;
  logic r_delay_done;
  logic b_delay_done;

  assign ar_hs = ARvalid & ARready;
  assign aw_hs = AWvalid & AWready;
  assign w_hs  = Wvalid & Wready;

  // The write commits on the edge where the last of AW/W arrives
  assign commit = resetn & (((w_state == W_IDLE) & aw_hs & w_hs) |
                            ((w_state == W_GOT_A) & w_hs) |
                            ((w_state == W_GOT_D) & aw_hs));

  assign wr_idx  = (w_state == W_GOT_A) ? aw_idx_q : AWdata[ADDR_W+1:2];
  assign wr_data = (w_state == W_GOT_D) ? w_data_q : Wdata;
  assign wr_strb = (w_state == W_GOT_D) ? w_strb_q : Wstrb;

  assign rd_en = resetn & ar_hs & (r_state == R_IDLE);

  // Protection, sub-word and out-of-range address bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{awprot, arprot, AWdata[1:0], ARdata[1:0],
                         AWdata[DATA_W-1:ADDR_W+2], ARdata[DATA_W-1:ADDR_W+2],
                         4'(WAIT_CYCLES)};

`ifdef AXI_MEM_WAIT_EN
  localparam logic [4:0] WAIT_LIM  = 5'(WAIT_CYCLES);
  localparam logic       IMMEDIATE = (WAIT_CYCLES <= 1);

  logic [3:0] ar_cnt;
  logic [3:0] aw_cnt;
  logic [3:0] ar_cnt_nxt;
  logic [3:0] aw_cnt_nxt;

  // While idle the counters track consecutive valid cycles; any gap restarts them
  assign ar_cnt_nxt   = ARvalid ? sat_inc(ar_cnt) : 4'd0;
  assign aw_cnt_nxt   = AWvalid ? sat_inc(aw_cnt) : 4'd0;
  assign ar_rdy_nxt   = ({1'b0, ar_cnt_nxt} + 5'd1) >= WAIT_LIM;
  assign aw_rdy_nxt   = ({1'b0, aw_cnt_nxt} + 5'd1) >= WAIT_LIM;
  assign r_delay_done = ({1'b0, ar_cnt} + 5'd1) >= WAIT_LIM;
  assign b_delay_done = ({1'b0, aw_cnt} + 5'd1) >= WAIT_LIM;

  // Read counter: valid-run length while idle, then response delay after the handshake
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ar_cnt <= 4'd0;
    end else begin
      case (r_state)
        R_IDLE:  ar_cnt <= ar_hs ? 4'd1 : ar_cnt_nxt;
        R_DATA:  ar_cnt <= (Rvalid && RReady) ? 4'd0 : (Rvalid ? ar_cnt : sat_inc(ar_cnt));
        default: ar_cnt <= 4'd0;
      endcase
    end
  end

  // Write counter: AWvalid-run length before the address lands, then response delay after commit
  always_ff @(posedge clock) begin
    if (!resetn) begin
      aw_cnt <= 4'd0;
    end else begin
      case (w_state)
        W_IDLE:  aw_cnt <= aw_hs ? (w_hs ? 4'd1 : 4'd0) : aw_cnt_nxt;
        W_GOT_A: aw_cnt <= w_hs ? 4'd1 : 4'd0;
        W_GOT_D: aw_cnt <= aw_hs ? 4'd1 : aw_cnt_nxt;
        W_RESP:  aw_cnt <= (Bvalid && Bready) ? 4'd0 : (Bvalid ? aw_cnt : sat_inc(aw_cnt));
        default: aw_cnt <= 4'd0;
      endcase
    end
  end
`else
  localparam logic IMMEDIATE = 1'b1;

  assign ar_rdy_nxt   = 1'b1;
  assign aw_rdy_nxt   = 1'b1;
  assign r_delay_done = 1'b1;
  assign b_delay_done = 1'b1;
`endif

  // Read channel FSM: accept one address, present data, hold it until RReady
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      ARready <= 1'b0;
      Rvalid  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            ARready <= 1'b0;
            Rvalid  <= IMMEDIATE;
            r_state <= R_DATA;
          end else begin
            ARready <= ar_rdy_nxt;
          end
        end
        R_DATA: begin
          if (Rvalid && RReady) begin
            Rvalid  <= 1'b0;
            ARready <= IMMEDIATE;
            r_state <= R_IDLE;
          end else if (!Rvalid && r_delay_done) begin
            Rvalid <= 1'b1;
          end
        end
        default: begin
          ARready <= 1'b0;
          Rvalid  <= 1'b0;
          r_state <= R_IDLE;
        end
      endcase
    end
  end

  // Write channel FSM: collect AW and W in either order, commit, then hold B until Bready
  always_ff @(posedge clock) begin
    if (!resetn) begin
      w_state  <= W_IDLE;
      AWready  <= 1'b0;
      Wready   <= 1'b0;
      Bvalid   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            AWready <= 1'b0;
            Wready  <= 1'b0;
            Bvalid  <= IMMEDIATE;
            w_state <= W_RESP;
          end else if (aw_hs) begin
            aw_idx_q <= AWdata[ADDR_W+1:2];
            AWready  <= 1'b0;
            Wready   <= 1'b1;
            w_state  <= W_GOT_A;
          end else if (w_hs) begin
            w_data_q <= Wdata;
            w_strb_q <= Wstrb;
            Wready   <= 1'b0;
            AWready  <= aw_rdy_nxt;
            w_state  <= W_GOT_D;
          end else begin
            Wready  <= 1'b1;
            AWready <= aw_rdy_nxt;
          end
        end
        W_GOT_A: begin
          if (w_hs) begin
            Wready  <= 1'b0;
            Bvalid  <= IMMEDIATE;
            w_state <= W_RESP;
          end
        end
        W_GOT_D: begin
          if (aw_hs) begin
            AWready <= 1'b0;
            Bvalid  <= IMMEDIATE;
            w_state <= W_RESP;
          end else begin
            AWready <= aw_rdy_nxt;
          end
        end
        W_RESP: begin
          if (Bvalid && Bready) begin
            Bvalid  <= 1'b0;
            AWready <= IMMEDIATE;
            Wready  <= 1'b1;
            w_state <= W_IDLE;
          end else if (!Bvalid && b_delay_done) begin
            Bvalid <= 1'b1;
          end
        end
        default: begin
          AWready <= 1'b0;
          Wready  <= 1'b0;
          Bvalid  <= 1'b0;
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  mem_ram_bytewe #(
    .DEPTH (MEM_WORDS),
    .AW    (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .rd_clr  (!resetn),
    .rd_en   (rd_en),
    .rd_idx  (ARdata[ADDR_W+1:2]),
    .rd_data (Rdata),
    .wr_en   (commit),
    .wr_idx  (wr_idx),
    .wr_strb (wr_strb),
    .wr_data (wr_data)
  );

endmodule
